matinv_seq_ctrl: RTL

//  Sequencer wrapping the combinational fixed-point inverter matinv<N>.

---
 rtl/matinv_pkg.sv | 16 +
 rtl/matinv_elem_mux.sv | 19 +
 rtl/matinv_seq_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/matinv_pkg.sv
// Shared definitions for the matrix-inverter sequencer: FSM encoding and index sizing.
package matinv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matinv_elem_mux.sv
// E-way element selector over a packed matrix bus; picks element sel_i for the output stream.
module matinv_elem_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int ELEMS      = 9,
  parameter int IDX_W      = 4
) (
  input  logic [ELEMS*DATA_WIDTH-1:0] bus_i,
  input  logic [IDX_W-1:0]            sel_i,
  output logic [DATA_WIDTH-1:0]       data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < ELEMS; i++) begin
      if (sel_i == IDX_W'(i)) data_o = bus_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/matinv_seq_ctrl.sv
// Load/settle/drain sequencer around an external combinational matinv<N> inverter.
// Optional MATINV_DONE_CNT_EN adds a 16-bit wrapping count of completed inverses.
module matinv_seq_ctrl
  import matinv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int BIN_POS       = 16,
  parameter int MATRIX_SIZE   = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [DATA_WIDTH-1:0]                           in_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [DATA_WIDTH-1:0]                           out_data,
  output logic                                            out_last,
  output logic                                            busy,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   mat_bus,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   inv_bus
`ifdef MATINV_DONE_CNT_EN
  ,output logic [15:0]                                    done_count
`endif
);

  localparam int E     = MATRIX_SIZE * MATRIX_SIZE;
  localparam int BUS_W = E * DATA_WIDTH;
  localparam int IDX_W = idx_width(E);
  localparam int CNT_W = idx_width(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(E - 1);

  // BIN_POS only matters to the inverter; it is still range-checked here.
  if (MATRIX_SIZE < 2 || SETTLE_CYCLES < 1 || BIN_POS < 0 || BIN_POS >= DATA_WIDTH) begin : g_param_check
    $error("matinv_seq_ctrl: illegal parameter combination");
  end

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BUS_W-1:0]        mat_q, mat_d;
  logic [BUS_W-1:0]        cap_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic                    cap_en;
  logic                    fin_hs;
  logic [DATA_WIDTH-1:0]   mux_data;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mat_d    = mat_q;
    cap_en   = 1'b0;
    fin_hs   = 1'b0;
    in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (in_valid) begin
          mat_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            cnt_d   = CNT_W'(SETTLE_CYCLES);
            state_d = ST_SETTLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          cap_en  = 1'b1;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            fin_hs  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Output register tracks the element that will be current after this edge.
  matinv_elem_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ELEMS      (E),
    .IDX_W      (IDX_W)
  ) u_elem_mux (
    .bus_i  (cap_q),
    .sel_i  (idx_d),
    .data_o (mux_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      mat_q       <= '0;
      cap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
      if (cap_en) cap_q <= inv_bus;
      if (state_q == ST_DRAIN && !fin_hs) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mux_data;
        out_last_q  <= (idx_d == IDX_LAST);
      end else begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

`ifdef MATINV_DONE_CNT_EN
  logic [15:0] done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      done_q <= '0;
    else if (fin_hs) done_q <= done_q + 16'd1;
  end

  assign done_count = done_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign mat_bus   = mat_q;

endmodule
